// File: rtl/branch_resolve_ctrl.sv
// Execute-stage branch sequencer: hands one branch at a time to the registered comparator,
// checks the outcome against a BTFN guess, and on a mispredict redirects fetch and flushes.
module branch_resolve_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [XLEN-1:0]  br_pc,
    input  logic [31:0]      br_instr,
    input  logic [XLEN-1:0]  br_rs1,
    input  logic [XLEN-1:0]  br_rs2,
    input  logic             kill,
    output logic [XLEN-1:0]  cmp_rs1,
    output logic [XLEN-1:0]  cmp_rs2,
    output logic [31:0]      cmp_instr,
    input  logic             cmp_taken,
    output logic             resolve_valid,
    output logic             resolve_taken,
    output logic             illegal_br,
    output logic             redirect_valid,
    input  logic             redirect_ready,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CMP      = 2'd1,
        S_RESOLVE  = 2'd2,
        S_REDIRECT = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  cmp_rs1_q, cmp_rs1_d;
    logic [XLEN-1:0]  cmp_rs2_q, cmp_rs2_d;
    logic [31:0]      cmp_instr_q, cmp_instr_d;
    logic             pred_taken_q, pred_taken_d;
    logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
    logic             flush_q, flush_d;
    logic [CNT_W-1:0] br_count_q, br_count_d;
    logic [CNT_W-1:0] mispred_count_q, mispred_count_d;

    logic             accept;
    logic             is_illegal;
    logic             outcome;
    logic             mispredict;
    logic [XLEN-1:0]  imm_ext;
    logic [XLEN-1:0]  target_pc;
    logic [XLEN-1:0]  fall_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            pc_q            <= '0;
            cmp_rs1_q       <= '0;
            cmp_rs2_q       <= '0;
            cmp_instr_q     <= '0;
            pred_taken_q    <= 1'b0;
            redirect_pc_q   <= '0;
            flush_q         <= 1'b0;
            br_count_q      <= '0;
            mispred_count_q <= '0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            cmp_rs1_q       <= cmp_rs1_d;
            cmp_rs2_q       <= cmp_rs2_d;
            cmp_instr_q     <= cmp_instr_d;
            pred_taken_q    <= pred_taken_d;
            redirect_pc_q   <= redirect_pc_d;
            flush_q         <= flush_d;
            br_count_q      <= br_count_d;
            mispred_count_q <= mispred_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (br_valid) state_d = S_CMP;
            S_CMP:      state_d = kill ? S_IDLE : S_RESOLVE;
            S_RESOLVE:  state_d = mispredict ? S_REDIRECT : S_IDLE;
            S_REDIRECT: if (redirect_ready) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // funct3 010/011 are not branch encodings; such an instruction resolves as not taken.
    always_comb begin
        br_ready       = (state_q == S_IDLE);
        accept         = br_ready && br_valid;
        is_illegal     = (cmp_instr_q[14:13] == 2'b01);
        outcome        = cmp_taken && !is_illegal;
        resolve_valid  = (state_q == S_RESOLVE) && !kill;
        resolve_taken  = resolve_valid && outcome;
        illegal_br     = resolve_valid && is_illegal;
        mispredict     = resolve_valid && (outcome != pred_taken_q);
        redirect_valid = (state_q == S_REDIRECT);
    end

    assign imm_ext   = {{(XLEN-12){cmp_instr_q[31]}}, cmp_instr_q[7], cmp_instr_q[30:25],
                        cmp_instr_q[11:8], 1'b0};
    assign target_pc = pc_q + imm_ext;
    assign fall_pc   = pc_q + XLEN'(4);

    always_comb begin
        pc_d            = pc_q;
        cmp_rs1_d       = cmp_rs1_q;
        cmp_rs2_d       = cmp_rs2_q;
        cmp_instr_d     = cmp_instr_q;
        pred_taken_d    = pred_taken_q;
        redirect_pc_d   = redirect_pc_q;
        flush_d         = mispredict;
        br_count_d      = br_count_q;
        mispred_count_d = mispred_count_q;
        if (accept) begin
            pc_d         = br_pc;
            cmp_rs1_d    = br_rs1;
            cmp_rs2_d    = br_rs2;
            cmp_instr_d  = br_instr;
            pred_taken_d = br_instr[31];
        end
        if (resolve_valid) br_count_d = br_count_q + CNT_W'(1);
        if (mispredict) begin
            mispred_count_d = mispred_count_q + CNT_W'(1);
            redirect_pc_d   = outcome ? target_pc : fall_pc;
        end
    end

    assign cmp_rs1       = cmp_rs1_q;
    assign cmp_rs2       = cmp_rs2_q;
    assign cmp_instr     = cmp_instr_q;
    assign redirect_pc   = redirect_pc_q;
    assign flush         = flush_q;
    assign br_count      = br_count_q;
    assign mispred_count = mispred_count_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl with a behavioural registered comparator.
module tb_branch_resolve_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        br_valid;
    logic        br_ready;
    logic [31:0] br_pc, br_instr, br_rs1, br_rs2;
    logic        kill;
    logic [31:0] cmp_rs1, cmp_rs2, cmp_instr;
    logic        cmp_taken;
    logic        resolve_valid, resolve_taken, illegal_br;
    logic        redirect_valid, redirect_ready;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [31:0] br_count, mispred_count;

    int vectors = 0;
    int miscompares = 0;

    // {br_ready, resolve_valid, resolve_taken, illegal_br, flush, redirect_valid}
    logic [5:0] st;
    assign st = {br_ready, resolve_valid, resolve_taken, illegal_br, flush, redirect_valid};

    branch_resolve_ctrl #(.XLEN(32), .CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .br_valid(br_valid), .br_ready(br_ready),
        .br_pc(br_pc), .br_instr(br_instr), .br_rs1(br_rs1), .br_rs2(br_rs2),
        .kill(kill),
        .cmp_rs1(cmp_rs1), .cmp_rs2(cmp_rs2), .cmp_instr(cmp_instr), .cmp_taken(cmp_taken),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken), .illegal_br(illegal_br),
        .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
        .redirect_pc(redirect_pc), .flush(flush),
        .br_count(br_count), .mispred_count(mispred_count)
    );

    always #5 clk = ~clk;

    // Registered comparator; the non-branch funct3 codes report taken so forcing is visible.
    function automatic logic cmp_eval(input logic [31:0] a, input logic [31:0] b,
                                      input logic [2:0] f3);
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) < $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b1;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) cmp_taken <= 1'b0;
        else       cmp_taken <= cmp_eval(cmp_rs1, cmp_rs2, cmp_instr[14:12]);
    end

    function automatic logic [31:0] enc_b(input int imm, input logic [2:0] f3);
        logic [12:0] im;
        im = imm[12:0];
        return {im[12], im[10:5], 5'd2, 5'd1, f3, im[4:1], im[11], 7'b1100011};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic present(input logic [31:0] pc, input logic [31:0] instr,
                           input logic [31:0] rs1, input logic [31:0] rs2);
        br_valid = 1'b1;
        br_pc    = pc;
        br_instr = instr;
        br_rs1   = rs1;
        br_rs2   = rs2;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        vectors++;
        if (st !== 6'b100000) begin
            miscompares++;
            $display("FAIL reset_status: got %b expected %b", st, 6'b100000);
        end
        vectors++;
        if ({cmp_rs1, cmp_rs2, cmp_instr, redirect_pc} !== 128'h0) begin
            miscompares++;
            $display("FAIL reset_regs: got %h %h %h %h expected all zero",
                     cmp_rs1, cmp_rs2, cmp_instr, redirect_pc);
        end
        vectors++;
        if ({br_count, mispred_count} !== 64'h0) begin
            miscompares++;
            $display("FAIL reset_counts: got %0d/%0d expected 0/0", br_count, mispred_count);
        end
    endtask

    task automatic test_beq();
        present(32'h100, enc_b(-8, 3'b000), 32'd5, 32'd5);
        tick();
        br_valid = 1'b0;
        vectors++;
        if (st !== 6'b000000 || cmp_rs1 !== 32'd5 || cmp_instr !== enc_b(-8, 3'b000)) begin
            miscompares++;
            $display("FAIL beq_cmp: got st=%b rs1=%h instr=%h expected st=000000 rs1=5",
                     st, cmp_rs1, cmp_instr);
        end
        tick();
        vectors++;
        if (st !== 6'b011000) begin
            miscompares++;
            $display("FAIL beq_resolve: got %b expected %b", st, 6'b011000);
        end
        tick();
        vectors++;
        if (st !== 6'b100000 || br_count !== 32'd1 || mispred_count !== 32'd0) begin
            miscompares++;
            $display("FAIL beq_after: got st=%b cnt=%0d/%0d expected st=100000 cnt=1/0",
                     st, br_count, mispred_count);
        end
    endtask

    task automatic test_blt_redirect();
        present(32'h200, enc_b(32'h20, 3'b100), 32'hFFFF_FFFF, 32'd1);
        tick();
        br_valid = 1'b0;
        tick();
        vectors++;
        if (st !== 6'b011000) begin
            miscompares++;
            $display("FAIL blt_resolve: got %b expected %b", st, 6'b011000);
        end
        tick();
        vectors++;
        if (st !== 6'b000011 || redirect_pc !== 32'h220 || mispred_count !== 32'd1
            || br_count !== 32'd2) begin
            miscompares++;
            $display("FAIL blt_flush: got st=%b pc=%h cnt=%0d/%0d expected st=000011 pc=220 cnt=2/1",
                     st, redirect_pc, br_count, mispred_count);
        end
        // Decode offers a new branch during the redirect; it must not be taken.
        present(32'h900, enc_b(-8, 3'b000), 32'd0, 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if (st !== 6'b000001 || redirect_pc !== 32'h220) begin
                miscompares++;
                $display("FAIL blt_hold%0d: got st=%b pc=%h expected st=000001 pc=220",
                         i, st, redirect_pc);
            end
        end
        br_valid = 1'b0;
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        vectors++;
        if (st !== 6'b100000 || cmp_rs1 !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL blt_exit: got st=%b rs1=%h expected st=100000 rs1=ffffffff",
                     st, cmp_rs1);
        end
    endtask

    task automatic test_bgeu_not_taken();
        present(32'h300, enc_b(-16, 3'b111), 32'd1, 32'hFFFF_FFFF);
        tick();
        br_valid = 1'b0;
        tick();
        vectors++;
        if (st !== 6'b010000) begin
            miscompares++;
            $display("FAIL bgeu_resolve: got %b expected %b", st, 6'b010000);
        end
        tick();
        redirect_ready = 1'b1;
        vectors++;
        if (st !== 6'b000011 || redirect_pc !== 32'h304 || mispred_count !== 32'd2) begin
            miscompares++;
            $display("FAIL bgeu_redirect: got st=%b pc=%h mis=%0d expected st=000011 pc=304 mis=2",
                     st, redirect_pc, mispred_count);
        end
        tick();
        redirect_ready = 1'b0;
        vectors++;
        if (st !== 6'b100000) begin
            miscompares++;
            $display("FAIL bgeu_exit: got %b expected %b", st, 6'b100000);
        end
    endtask

    task automatic test_kill();
        present(32'h100, enc_b(-8, 3'b000), 32'd5, 32'd5);
        tick();
        br_valid = 1'b0;
        kill = 1'b1;
        tick();
        kill = 1'b0;
        vectors++;
        if (st !== 6'b100000) begin
            miscompares++;
            $display("FAIL kill_cmp: got %b expected %b", st, 6'b100000);
        end
        present(32'h200, enc_b(32'h20, 3'b100), 32'hFFFF_FFFF, 32'd1);
        tick();
        br_valid = 1'b0;
        tick();
        kill = 1'b1;
        #1;
        vectors++;
        if (st !== 6'b000000) begin
            miscompares++;
            $display("FAIL kill_resolve: got %b expected %b", st, 6'b000000);
        end
        tick();
        kill = 1'b0;
        vectors++;
        if (st !== 6'b100000 || br_count !== 32'd3 || mispred_count !== 32'd2) begin
            miscompares++;
            $display("FAIL kill_after: got st=%b cnt=%0d/%0d expected st=100000 cnt=3/2",
                     st, br_count, mispred_count);
        end
    endtask

    task automatic test_illegal();
        present(32'h400, enc_b(-4, 3'b010), 32'd0, 32'd0);
        tick();
        br_valid = 1'b0;
        tick();
        vectors++;
        if (st !== 6'b010100) begin
            miscompares++;
            $display("FAIL illegal_resolve: got %b expected %b", st, 6'b010100);
        end
        tick();
        redirect_ready = 1'b1;
        vectors++;
        if (st !== 6'b000011 || redirect_pc !== 32'h404 || br_count !== 32'd4
            || mispred_count !== 32'd3) begin
            miscompares++;
            $display("FAIL illegal_redirect: got st=%b pc=%h cnt=%0d/%0d expected st=000011 pc=404 cnt=4/3",
                     st, redirect_pc, br_count, mispred_count);
        end
        tick();
        redirect_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        present(32'h500, enc_b(-8, 3'b000), 32'd7, 32'd7);
        tick();
        present(32'h600, enc_b(8, 3'b001), 32'd3, 32'd3);
        tick();
        vectors++;
        if (st !== 6'b011000 || cmp_rs1 !== 32'd7) begin
            miscompares++;
            $display("FAIL b2b_first: got st=%b rs1=%h expected st=011000 rs1=7", st, cmp_rs1);
        end
        tick();
        vectors++;
        if (st !== 6'b100000) begin
            miscompares++;
            $display("FAIL b2b_ready: got %b expected %b", st, 6'b100000);
        end
        tick();
        br_valid = 1'b0;
        vectors++;
        if (cmp_rs1 !== 32'd3 || cmp_instr !== enc_b(8, 3'b001)) begin
            miscompares++;
            $display("FAIL b2b_latch: got rs1=%h instr=%h expected rs1=3", cmp_rs1, cmp_instr);
        end
        tick();
        vectors++;
        if (st !== 6'b010000) begin
            miscompares++;
            $display("FAIL b2b_second: got %b expected %b", st, 6'b010000);
        end
        tick();
        vectors++;
        if (br_count !== 32'd6 || mispred_count !== 32'd3) begin
            miscompares++;
            $display("FAIL b2b_counts: got %0d/%0d expected 6/3", br_count, mispred_count);
        end
    endtask

    task automatic test_reset_in_redirect();
        present(32'h200, enc_b(32'h20, 3'b100), 32'hFFFF_FFFF, 32'd1);
        tick();
        br_valid = 1'b0;
        tick();
        tick();
        vectors++;
        if (redirect_valid !== 1'b1 || mispred_count !== 32'd4) begin
            miscompares++;
            $display("FAIL rst_pre: got rv=%b mis=%0d expected rv=1 mis=4",
                     redirect_valid, mispred_count);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if (st !== 6'b100000 || br_count !== 32'd0 || mispred_count !== 32'd0
            || redirect_pc !== 32'd0 || cmp_rs1 !== 32'd0) begin
            miscompares++;
            $display("FAIL rst_redirect: got st=%b cnt=%0d/%0d pc=%h rs1=%h expected st=100000 zeros",
                     st, br_count, mispred_count, redirect_pc, cmp_rs1);
        end
    endtask

    initial begin
        reset = 1'b1;
        br_valid = 1'b0;
        br_pc = '0;
        br_instr = '0;
        br_rs1 = '0;
        br_rs2 = '0;
        kill = 1'b0;
        redirect_ready = 1'b0;
        test_reset();
        test_beq();
        test_blt_redirect();
        test_bgeu_not_taken();
        test_kill();
        test_illegal();
        test_back_to_back();
        test_reset_in_redirect();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
- Sequences the registered branch comparator for one conditional branch at a time, from the execute-stage front end.
- Accepts a branch from decode with a valid/ready handshake and drives the comparator with stable operands.
- Waits one cycle for the comparator's registered result, then checks it against a static BTFN prediction (backward taken, forward not taken).
- On a mispredict, issues a held redirect to fetch plus a flush pulse, and keeps branch and mispredict statistics.

Parameters:
- XLEN, 32, data/PC width.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- br_valid  in  1  decode offers a branch.
- br_ready  out  1  controller can accept a branch.
- br_pc  in  XLEN  PC of the offered branch.
- br_instr  in  32  instruction word.
- br_rs1  in  XLEN  rs1 operand value.
- br_rs2  in  XLEN  rs2 operand value.
- kill  in  1  upstream squash of the in-flight branch.
- cmp_rs1  out  XLEN  operand to comparator.
- cmp_rs2  out  XLEN  operand to comparator.
- cmp_instr  out  32  instruction to comparator.
- cmp_taken  in  1  comparator's registered branch_taken.
- resolve_valid  out  1  one-cycle pulse: branch resolved.
- resolve_taken  out  1  actual outcome; qualified by resolve_valid.
- illegal_br  out  1  one-cycle pulse with resolve_valid when funct3 is not a legal branch encoding.
- redirect_valid  out  1  fetch redirect request.
- redirect_ready  in  1  fetch accepts the redirect.
- redirect_pc  out  XLEN  corrected next PC.
- flush  out  1  one-cycle pulse to squash younger instructions.
- br_count  out  CNT_W  branches resolved.
- mispred_count  out  CNT_W  mispredicts.

Behaviour:
- Reset: state IDLE. br_ready=1. All other outputs 0, including latched operands, counters and redirect_pc.
- Reset wins over every other event in every state; it abandons any in-flight branch or pending redirect.
- The comparator shares clk and reset.
- States: IDLE, CMP, RESOLVE, REDIRECT. br_ready=1 only in IDLE.
- IDLE:
  - Accept when br_valid && br_ready (edge E0).
  - Latch pc, instr, rs1, rs2 into the cmp_* registers; they are held constant until the next accept.
  - Compute pred_taken = B-immediate sign bit (instr[31]).
  - Next state CMP.
- CMP (cycle E0+1):
  - Comparator samples cmp_* at the closing edge.
  - Next state RESOLVE.
- RESOLVE (cycle E0+2):
  - cmp_taken is valid in this cycle. resolve_valid=1, resolve_taken=cmp_taken.
  - If funct3 ∈ {010, 011}: illegal_br=1 and outcome forced to 0.
  - br_count increments at the closing edge.
  - If outcome == pred_taken: next state IDLE.
  - Otherwise: mispred_count increments, redirect_pc is registered, flush pulses for one cycle at E0+3, next state REDIRECT.
- Target arithmetic:
  - imm = sign-extended {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - Target = pc + imm; fall-through = pc + 4; both modulo 2^XLEN (wrap, no trap).
  - redirect_pc = target when the outcome is taken, else fall-through.
- REDIRECT:
  - redirect_valid=1; redirect_pc held stable.
  - Leave for IDLE on the edge where redirect_ready=1.
  - Minimum redirect_valid duration: 1 cycle. No new branch is accepted until exit.
- kill:
  - Sampled in CMP and RESOLVE: go to IDLE next edge. No resolve_valid, flush, redirect or count update.
  - kill during RESOLVE suppresses that cycle's resolve_valid combinationally.
  - kill is ignored in IDLE and REDIRECT; a redirect already issued must complete.
- Counters wrap at 2^CNT_W.
- Throughput: one branch per 3 cycles without a mispredict. Decode latency to resolve: 2 cycles.

Test Plan:
- BEQ, pc=0x100, imm=-8, rs1=rs2=5 → resolve_valid at E0+2, taken=1, predicted taken, no flush/redirect; br_count=1, mispred_count=0; br_ready high again at E0+3.
- BLT, pc=0x200, imm=+0x20, rs1=0xFFFFFFFF, rs2=1 → taken, mispredict; flush pulse at E0+3; redirect_valid with redirect_pc=0x220 held through 3 cycles of redirect_ready=0, dropped the cycle after ready=1; mispred_count=1.
- BGEU, pc=0x300, imm=-0x10, rs1=1, rs2=0xFFFFFFFF → not taken vs predicted taken; redirect_pc=0x304.
- kill asserted in CMP, then separately in RESOLVE → no resolve_valid, no flush, counters unchanged, br_ready=1 next cycle.
- funct3=010, pc=0x400, imm=-4 → illegal_br and resolve_valid together, taken=0; mispredict redirect to 0x404.
- Back-to-back accepts with br_valid held high, and reset asserted mid-REDIRECT → redirect_valid=0 and counters=0 on the next cycle, br_ready=1.
